// File: rtl/rs_latch_monitor.sv
// rs_latch_monitor: clocked response checker for an active-high NOR RS latch with settle window and saturating counts
module rs_latch_monitor #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             q_bar,
  output logic             ref_q,
  output logic             ref_valid,
  output logic             chk_pulse,
  output logic             err_pulse,
  output logic             inv_pulse,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;
  localparam logic [3:0] LOAD = 4'(SETTLE - 1);
  state_t state;
  logic [1:0] sr, sr_d;
  logic [3:0] cnt;
  logic change, known_pass, comp_pass, pass;
  assign sr     = {s, r};
  assign change = sr != sr_d;
  // Identity compares make an X/Z on q or q_bar count as a failure in simulation.
  assign known_pass = (q === ref_q) && (q_bar === ~ref_q);
  assign comp_pass  = (q === 1'b1 && q_bar === 1'b0) || (q === 1'b0 && q_bar === 1'b1);
  assign pass = (sr_d == 2'b11) ? (q === 1'b0 && q_bar === 1'b0) : ref_valid ? known_pass : comp_pass;
  // Stimulus sampling, latch reference model and invalid-input detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_d      <= 2'b00;
      ref_q     <= 1'b0;
      ref_valid <= 1'b0;
      inv_pulse <= 1'b0;
    end else begin
      sr_d      <= sr;
      inv_pulse <= change && sr == 2'b11;
      if (change && sr == 2'b10) begin
        ref_q     <= 1'b1;
        ref_valid <= 1'b1;
      end else if (change && sr == 2'b01) begin
        ref_q     <= 1'b0;
        ref_valid <= 1'b1;
      end else if (change && sr == 2'b00 && sr_d == 2'b11) begin
        ref_valid <= 1'b0;
      end
    end
  end
  // Settle FSM: a change (re)starts the window; CHECK performs one compare and updates the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      chk_pulse <= 1'b0;
      err_pulse <= 1'b0;
      chk_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      chk_pulse <= state == CHECK;
      err_pulse <= state == CHECK && !pass;
      if (state == CHECK) chk_cnt <= chk_cnt + CNT_W'(chk_cnt != '1);
      if (state == CHECK && !pass) err_cnt <= err_cnt + CNT_W'(err_cnt != '1);
      if (change) begin
        state <= WAIT;
        cnt   <= LOAD;
      end else if (state == WAIT && cnt == 4'd0) begin
        state <= CHECK;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
